uart_receiver: RTL and testbench

// Receive end of the project UART link: takes the serial line driven by the transmitter
// and recovers 8-bit bytes. Frame: start bit(0), 8 data bits LSB first, even parity, stop(1).

---
 rtl/uart_receiver.sv | 165 ++++++++++++++++
 tb/tb_uart_receiver.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// rtl/uart_receiver.sv - 16x oversampled 8E1 UART receiver with parity and framing checks
module uart_receiver #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Rx_EN,
  input  logic       RxD,
  output logic [7:0] Rx_DATA,
  output logic       Rx_VALID,
  output logic       Rx_PERROR,
  output logic       Rx_FERROR,
  output logic       Rx_BUSY
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] TICK_MID = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] TICK_END = 4'(OVERSAMPLE - 1);

  // Rounded divisor: (f + 8*baud) / (16*baud)
  function automatic logic [15:0] baud_div(input logic [2:0] sel);
    int baud;
    case (sel)
      3'b000:  baud = 300;
      3'b001:  baud = 1200;
      3'b010:  baud = 4800;
      3'b011:  baud = 9600;
      3'b100:  baud = 19200;
      3'b101:  baud = 38400;
      3'b110:  baud = 57600;
      default: baud = 115200;
    endcase
    return 16'((CLK_FREQ + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud));
  endfunction

  logic        rx_meta_q, rx_sync_q;
  logic [2:0]  baud_q;
  logic [15:0] div_cnt_q, div_cnt_d, div_last;
  logic        tick;

  state_t      state_q;
  logic [3:0]  tcnt_q;
  logic [2:0]  bcnt_q;
  logic [7:0]  shift_q, data_q;
  logic        perr_q, valid_q, perror_q, ferror_q, busy_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RxD;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign div_last = baud_div(baud_select) - 16'd1;
  assign tick     = (baud_select == baud_q) && (div_cnt_q == div_last);

  always_comb begin
    div_cnt_d = div_cnt_q + 16'd1;
    if ((baud_select != baud_q) || tick) div_cnt_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      baud_q    <= 3'b000;
      div_cnt_q <= '0;
    end else begin
      baud_q    <= baud_select;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tcnt_q   <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perror_q <= 1'b0;
      ferror_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!Rx_EN) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else if (tick) begin
        case (state_q)
          IDLE: begin
            if (!rx_sync_q) begin
              state_q  <= START;
              busy_q   <= 1'b1;
              tcnt_q   <= '0;
              perror_q <= 1'b0;
              ferror_q <= 1'b0;
            end
          end
          START: begin
            if (tcnt_q == TICK_MID) begin
              if (!rx_sync_q) begin
                state_q <= DATA;
                tcnt_q  <= '0;
                bcnt_q  <= '0;
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tcnt_q <= tcnt_q + 4'd1;
            end
          end
          DATA: begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == TICK_END) begin
              shift_q <= {rx_sync_q, shift_q[7:1]};
              bcnt_q  <= bcnt_q + 3'd1;
              if (bcnt_q == 3'd7) state_q <= PARITY;
            end
          end
          PARITY: begin
            tcnt_q <= tcnt_q + 4'd1;
            if (tcnt_q == TICK_END) begin
              perr_q  <= rx_sync_q ^ (^shift_q);
              state_q <= STOP;
            end
          end
          STOP: begin
            tcnt_q <= tcnt_q + 4'd1;
            // Leave mid stop bit so a back-to-back start edge is caught
            if (tcnt_q == TICK_END) begin
              ferror_q <= ~rx_sync_q;
              perror_q <= perr_q;
              if (rx_sync_q && !perr_q) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Rx_DATA   = data_q;
  assign Rx_VALID  = valid_q;
  assign Rx_PERROR = perror_q;
  assign Rx_FERROR = ferror_q;
  assign Rx_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;

  localparam int BIT_FAST = 8680;
  localparam int BIT_9600 = 104167;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_select = 3'b111;
  logic       Rx_EN = 1'b0;
  logic       RxD = 1'b1;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID, Rx_PERROR, Rx_FERROR, Rx_BUSY;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0, valid_run = 0, valid_max = 0, busy_cnt = 0, ferr_cnt = 0;

  always #10 clock = ~clock;

  uart_receiver dut (
    .clock      (clock),
    .reset      (reset),
    .baud_select(baud_select),
    .Rx_EN      (Rx_EN),
    .RxD        (RxD),
    .Rx_DATA    (Rx_DATA),
    .Rx_VALID   (Rx_VALID),
    .Rx_PERROR  (Rx_PERROR),
    .Rx_FERROR  (Rx_FERROR),
    .Rx_BUSY    (Rx_BUSY)
  );

  always @(negedge clock) begin
    if (Rx_VALID) begin
      valid_cnt++;
      valid_run++;
      if (valid_run > valid_max) valid_max = valid_run;
    end else begin
      valid_run = 0;
    end
    if (Rx_BUSY) busy_cnt++;
    if (Rx_FERROR) ferr_cnt++;
  end

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input int bit_ns, input int stop_ns);
    RxD = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      RxD = data[i];
      #(bit_ns);
    end
    RxD = par;
    #(bit_ns);
    RxD = stop;
    #(stop_ns);
    RxD = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] data, input int nbits, input int bit_ns);
    RxD = 1'b0;
    #(bit_ns);
    for (int i = 0; i < nbits; i++) begin
      RxD = data[i];
      #(bit_ns);
    end
    RxD = data[nbits];
  endtask

  task automatic test_reset;
    reset = 1'b1; RxD = 1'b1; Rx_EN = 1'b1; baud_select = 3'b111;
    repeat (5) @(negedge clock);
    reset = 1'b0;
    #5000;
    @(negedge clock);
    checks++; if (Rx_DATA !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", Rx_DATA); end
    checks++; if (Rx_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Rx_VALID); end
    checks++; if (Rx_PERROR !== 1'b0) begin errors++; $display("FAIL reset_perror got %b want 0", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin errors++; $display("FAIL reset_ferror got %b want 0", Rx_FERROR); end
    checks++; if (Rx_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Rx_BUSY); end
    checks++; if (busy_cnt !== 0) begin errors++; $display("FAIL reset_busy_seen got %0d want 0", busy_cnt); end
    checks++; if (valid_cnt !== 0) begin errors++; $display("FAIL reset_valid_seen got %0d want 0", valid_cnt); end
  endtask

  task automatic test_good_frame;
    send_frame(8'hA8, 1'b1, 1'b1, BIT_FAST, BIT_FAST);
    checks++; if (valid_cnt !== 1) begin errors++; $display("FAIL good_valid_count got %0d want 1", valid_cnt); end
    checks++; if (valid_max !== 1) begin errors++; $display("FAIL good_valid_width got %0d want 1", valid_max); end
    checks++; if (Rx_DATA !== 8'hA8) begin errors++; $display("FAIL good_data got %h want a8", Rx_DATA); end
    checks++; if (Rx_PERROR !== 1'b0) begin errors++; $display("FAIL good_perror got %b want 0", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin errors++; $display("FAIL good_ferror got %b want 0", Rx_FERROR); end
  endtask

  task automatic test_back_to_back;
    send_frame(8'h17, 1'b0, 1'b1, BIT_FAST, BIT_FAST);
    @(negedge clock);
    checks++; if (valid_cnt !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d want 2", valid_cnt); end
    checks++; if (valid_max !== 1) begin errors++; $display("FAIL b2b_valid_width got %0d want 1", valid_max); end
    checks++; if (Rx_DATA !== 8'h17) begin errors++; $display("FAIL b2b_data got %h want 17", Rx_DATA); end
  endtask

  task automatic test_parity_error;
    send_frame(8'h55, 1'b1, 1'b1, BIT_FAST, BIT_FAST);
    @(negedge clock);
    checks++; if (Rx_PERROR !== 1'b1) begin errors++; $display("FAIL perr_flag got %b want 1", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin errors++; $display("FAIL perr_ferror got %b want 0", Rx_FERROR); end
    checks++; if (valid_cnt !== 2) begin errors++; $display("FAIL perr_no_valid got %0d want 2", valid_cnt); end
    checks++; if (Rx_DATA !== 8'h17) begin errors++; $display("FAIL perr_data_held got %h want 17", Rx_DATA); end
    send_frame(8'h3C, 1'b0, 1'b1, BIT_FAST, BIT_FAST);
    @(negedge clock);
    checks++; if (Rx_PERROR !== 1'b0) begin errors++; $display("FAIL perr_cleared got %b want 0", Rx_PERROR); end
    checks++; if (Rx_DATA !== 8'h3C) begin errors++; $display("FAIL perr_next_data got %h want 3c", Rx_DATA); end
    checks++; if (valid_cnt !== 3) begin errors++; $display("FAIL perr_next_valid got %0d want 3", valid_cnt); end
  endtask

  task automatic test_framing_and_glitch;
    int f_before, b_before;
    f_before = ferr_cnt;
    send_frame(8'hF0, 1'b0, 1'b0, BIT_FAST, BIT_FAST * 6 / 10);
    #20000;
    @(negedge clock);
    checks++; if (ferr_cnt <= f_before) begin errors++; $display("FAIL ferr_flag seen %0d cycles want >0", ferr_cnt - f_before); end
    checks++; if (valid_cnt !== 3) begin errors++; $display("FAIL ferr_no_valid got %0d want 3", valid_cnt); end
    checks++; if (Rx_DATA !== 8'h3C) begin errors++; $display("FAIL ferr_data_held got %h want 3c", Rx_DATA); end
    b_before = busy_cnt;
    RxD = 1'b0;
    #2000;
    RxD = 1'b1;
    #10000;
    @(negedge clock);
    checks++; if (busy_cnt <= b_before) begin errors++; $display("FAIL glitch_busy_pulse seen %0d cycles want >0", busy_cnt - b_before); end
    checks++; if (Rx_BUSY !== 1'b0) begin errors++; $display("FAIL glitch_idle got %b want 0", Rx_BUSY); end
    checks++; if (valid_cnt !== 3) begin errors++; $display("FAIL glitch_no_valid got %0d want 3", valid_cnt); end
    checks++; if (Rx_FERROR !== 1'b0) begin errors++; $display("FAIL glitch_clears_ferror got %b want 0", Rx_FERROR); end
  endtask

  task automatic test_slow_baud;
    baud_select = 3'b011;
    repeat (2) @(negedge clock);
    send_frame(8'h81, 1'b0, 1'b1, BIT_9600, BIT_9600 * 6 / 10);
    @(negedge clock);
    checks++; if (Rx_DATA !== 8'h81) begin errors++; $display("FAIL slow_data got %h want 81", Rx_DATA); end
    checks++; if (valid_cnt !== 4) begin errors++; $display("FAIL slow_valid got %0d want 4", valid_cnt); end
  endtask

  task automatic test_enable_abort;
    baud_select = 3'b111;
    repeat (2) @(negedge clock);
    send_partial(8'h42, 4, BIT_FAST);
    #(BIT_FAST / 2);
    checks++; if (Rx_BUSY !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", Rx_BUSY); end
    Rx_EN = 1'b0;
    @(posedge clock);
    @(negedge clock);
    checks++; if (Rx_BUSY !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", Rx_BUSY); end
    RxD = 1'b1;
    #(BIT_FAST * 4);
    checks++; if (valid_cnt !== 4) begin errors++; $display("FAIL abort_no_valid got %0d want 4", valid_cnt); end
    checks++; if (Rx_DATA !== 8'h81) begin errors++; $display("FAIL abort_data_held got %h want 81", Rx_DATA); end
    checks++; if (Rx_PERROR !== 1'b0) begin errors++; $display("FAIL abort_perror got %b want 0", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin errors++; $display("FAIL abort_ferror got %b want 0", Rx_FERROR); end
    Rx_EN = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clock);
    send_partial(8'h99, 3, BIT_FAST);
    #(BIT_FAST / 2);
    checks++; if (Rx_BUSY !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b want 1", Rx_BUSY); end
    #3;
    reset = 1'b1;
    #1;
    checks++; if (Rx_DATA !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", Rx_DATA); end
    checks++; if (Rx_VALID !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", Rx_VALID); end
    checks++; if (Rx_PERROR !== 1'b0) begin errors++; $display("FAIL rstmid_perror got %b want 0", Rx_PERROR); end
    checks++; if (Rx_FERROR !== 1'b0) begin errors++; $display("FAIL rstmid_ferror got %b want 0", Rx_FERROR); end
    checks++; if (Rx_BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", Rx_BUSY); end
    RxD = 1'b1;
    #100;
    @(negedge clock);
    reset = 1'b0;
    #(BIT_FAST * 4);
    @(negedge clock);
    checks++; if (Rx_BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_after_busy got %b want 0", Rx_BUSY); end
    checks++; if (Rx_DATA !== 8'h00) begin errors++; $display("FAIL rstmid_after_data got %h want 00", Rx_DATA); end
    checks++; if (valid_cnt !== 4) begin errors++; $display("FAIL rstmid_after_valid got %0d want 4", valid_cnt); end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_back_to_back;
    test_parity_error;
    test_framing_and_glitch;
    test_slow_baud;
    test_enable_abort;
    test_reset_mid_frame;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
